uart_tx_fifo: RTL and testbench

Byte FIFO and transmit sequencer between a byte producer (the UART receive path in the loopback design, or any other source) and the `uart` transmitter. It absorbs back-to-back bytes that arrive while the transmitter is busy and issues one `transmit` pulse per byte only when the transmitter is idle. It replaces the direct `received` → `transmit` coupling, which drops bytes under load. It reports occupancy and a sticky overflow flag.

---
 rtl/uart_tx_fifo.sv | 114 +++++++++++
 tb/tb_uart_tx_fifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of a UART transmitter. Bytes are queued as
// they arrive and handed to the UART one at a time with a single-cycle
// transmit pulse, only while the UART reports idle.
module uart_tx_fifo #(
  parameter int DEPTH      = 16,
  parameter int START_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  input  logic                   is_transmitting,
  input  logic                   clr_overflow,
  output logic                   transmit,
  output logic [7:0]             tx_byte,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (START_WAIT > 1) ? $clog2(START_WAIT) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE} state_e;

  state_e          state_q;
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            transmit_q;
  logic [7:0]      tx_byte_q;
  logic [TW-1:0]   timer_q;
  logic [7:0]      mem_q [DEPTH];

  logic            pop, push, drop, timeout;

  // Pop only on IDLE->LAUNCH; a pop frees a slot so a push into a full FIFO
  // in the same cycle is still accepted. The start timer gives up once the
  // next count would reach START_WAIT-1, so a deaf UART cannot stall us.
  always_comb begin
    pop        = (state_q == IDLE) && (count_q != '0) && !is_transmitting;
    push       = in_valid && (!full || pop);
    drop       = in_valid && full && !pop;
    timeout    = (int'(timer_q) + 1) >= (START_WAIT - 1);
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    overflow_d = overflow_q;
    if (clr_overflow) overflow_d = 1'b0;
    if (drop)         overflow_d = 1'b1;
  end

  // Storage array; contents are meaningless after reset so it is not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // Write pointer, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Transmit sequencer: owns read pointer, launch pulse and held byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      timer_q    <= '0;
      transmit_q <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      transmit_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            tx_byte_q  <= mem_q[rd_ptr_q];
            rd_ptr_q   <= rd_ptr_q + 1'b1;
            transmit_q <= 1'b1;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: begin
          timer_q <= '0;
          state_q <= WAIT_START;
        end
        WAIT_START: begin
          if (is_transmitting || timeout) state_q <= WAIT_DONE;
          else                            timer_q <= timer_q + 1'b1;
        end
        WAIT_DONE: begin
          if (!is_transmitting) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign transmit = transmit_q;
  assign tx_byte  = tx_byte_q;
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple busy-for-10-cycles UART model.
module tb_uart_tx_fifo;
  logic       clk, rst_n, in_valid, clr_overflow, transmit, empty, full, overflow;
  logic [7:0] in_data, tx_byte;
  logic [4:0] count;
  logic       tb_busy, model_en, is_tx;
  int         busy_cnt;
  int         cyc;
  int         total, bad;
  logic [7:0] txq[$];
  int         tcyc[$];

  uart_tx_fifo #(.DEPTH(16), .START_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .is_transmitting(is_tx), .clr_overflow(clr_overflow),
    .transmit(transmit), .tx_byte(tx_byte), .count(count),
    .empty(empty), .full(full), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign is_tx = model_en ? (busy_cnt != 0) : tb_busy;

  always @(posedge clk) cyc <= cyc + 1;

  // UART model: goes busy for 10 cycles after seeing a launch pulse
  always @(negedge clk) begin
    if (!model_en)          busy_cnt <= 0;
    else if (transmit)      busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  // record every launch: byte and cycle
  always @(negedge clk) begin
    if (transmit) begin
      txq.push_back(tx_byte);
      tcyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qbyte(input int i);
    return (txq.size() > i) ? 32'(txq[i]) : 32'h1FF;
  endfunction

  function automatic int qgap(input int i);
    return (tcyc.size() > i) ? tcyc[i] - tcyc[i-1] : -1;
  endfunction

  task automatic wait_pulses(input string tag, input int n, input int maxc);
    int k;
    k = 0;
    while (txq.size() < n && k < maxc) begin
      tick();
      k++;
    end
    chk(tag, 32'(txq.size()), 32'(n));
  endtask

  task automatic clearq();
    txq.delete();
    tcyc.delete();
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; clr_overflow = 1'b0;
    tb_busy = 1'b0; model_en = 1'b0;
    repeat (3) tick();
    chk("rst_transmit", 32'(transmit), 0);
    chk("rst_tx_byte",  32'(tx_byte),  0);
    chk("rst_count",    32'(count),    0);
    chk("rst_empty",    32'(empty),    1);
    chk("rst_full",     32'(full),     0);
    chk("rst_overflow", 32'(overflow), 0);
    rst_n = 1'b1;
    tick();

    // single byte, transmitter idle
    clearq();
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    chk("single_count1",  32'(count),    1);
    chk("single_noearly", 32'(transmit), 0);
    tick();
    chk("single_pulse",   32'(transmit), 1);
    chk("single_byte",    32'(tx_byte),  32'hA5);
    chk("single_count0",  32'(count),    0);
    tick();
    chk("single_onecyc",  32'(transmit), 0);
    chk("single_hold",    32'(tx_byte),  32'hA5);
    repeat (10) tick();
    chk("single_npulse",  32'(txq.size()), 1);

    // burst while busy, then drained by the UART model
    clearq();
    tb_busy = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("burst_count3", 32'(count), 3);
    repeat (3) tick();
    chk("burst_nopulse", 32'(txq.size()), 0);
    model_en = 1'b1;
    wait_pulses("burst_pulses", 3, 100);
    for (int i = 0; i < 3; i++) chk("burst_order", qbyte(i), 32'(i + 1));
    chk("burst_gap1", 32'(qgap(1) >= 11), 1);
    chk("burst_gap2", 32'(qgap(2) >= 11), 1);
    repeat (15) tick();
    model_en = 1'b0; tb_busy = 1'b0;
    tick();

    // overflow: 17 pushes while busy, last one dropped
    clearq();
    tb_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h10 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("ovf_full",  32'(full),     1);
    chk("ovf_count", 32'(count),    16);
    chk("ovf_flag",  32'(overflow), 1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("ovf_clear", 32'(overflow), 0);
    chk("ovf_keep",  32'(count),    16);

    // full FIFO: push lands in the same cycle as the pop
    tb_busy = 1'b0; in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    model_en = 1'b1;
    chk("fpop_count", 32'(count),    16);
    chk("fpop_ovf",   32'(overflow), 0);
    chk("fpop_pulse", 32'(transmit), 1);
    chk("fpop_byte",  32'(tx_byte),  32'h10);
    wait_pulses("fpop_pulses", 17, 300);
    for (int i = 0; i < 17; i++)
      chk("fpop_order", qbyte(i), (i < 16) ? 32'(8'h10 + i) : 32'h77);
    repeat (15) tick();
    model_en = 1'b0; tb_busy = 1'b0;
    tick();
    chk("fpop_empty", 32'(empty), 1);

    // start timeout: UART never raises busy
    clearq();
    in_valid = 1'b1; in_data = 8'h55;
    tick();
    in_data = 8'h66;
    tick();
    in_valid = 1'b0;
    chk("tmo_count", 32'(count), 1);
    wait_pulses("tmo_pulses", 2, 40);
    chk("tmo_b0",  qbyte(0), 32'h55);
    chk("tmo_b1",  qbyte(1), 32'h66);
    chk("tmo_gap", 32'(qgap(1)), 6);
    repeat (10) tick();

    // reset asserted during LAUNCH with 5 bytes still queued
    tb_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'(8'hA0 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("mid_count6", 32'(count), 6);
    tb_busy = 1'b0;
    tick();
    chk("mid_launch", 32'(transmit), 1);
    chk("mid_count5", 32'(count),    5);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_transmit", 32'(transmit), 0);
    chk("mid_tx_byte",  32'(tx_byte),  0);
    chk("mid_count",    32'(count),    0);
    chk("mid_empty",    32'(empty),    1);
    chk("mid_full",     32'(full),     0);
    chk("mid_ovf",      32'(overflow), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    clearq();
    tick();
    in_valid = 1'b1; in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    wait_pulses("post_pulse", 1, 20);
    chk("post_byte", qbyte(0), 32'h3C);
    repeat (20) tick();
    chk("post_only", 32'(txq.size()), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
